// File: rtl/regs_file_if.sv
// Bus bundle for the decode-stage register file: two read addresses with their
// combinational data, plus one write address/data/enable.
interface regs_file_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] A1;
   logic [ADDR_W-1:0] A2;
   logic [ADDR_W-1:0] A3;
   logic [DATA_W-1:0] WD3;
   logic              WE3;
   logic [DATA_W-1:0] RD1;
   logic [DATA_W-1:0] RD2;

   modport master (
      output A1, A2, A3, WD3, WE3,
      input  RD1, RD2
   );

   modport slave (
      input  A1, A2, A3, WD3, WE3,
      output RD1, RD2
   );
endinterface

// File: rtl/regs_file.sv
// MIPS-style 32x32 register file: two combinational read ports, one synchronous write port, $zero hardwired.
// Optional same-cycle write-to-read forwarding is enabled by defining REGS_FILE_WRITE_BYPASS_EN.
module regs_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic       clk,
   input  logic       rst,
   regs_file_if.slave bus
);
   localparam int NREGS = 2 ** ADDR_W;

   // Entry 0 is held at a constant zero on both paths, so synthesis trims it away.
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              wrValid;

   assign wrValid = bus.WE3 && (bus.A3 != '0);

   always_comb begin
      regs_d = regs_q;
      if (wrValid) begin
         regs_d[bus.A3] = bus.WD3;
      end
      regs_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Forwarding depends only on the write-port inputs, so reset leaves it active.
   always_comb begin
      rd1 = (bus.A1 == '0) ? '0 : regs_q[bus.A1];
      rd2 = (bus.A2 == '0) ? '0 : regs_q[bus.A2];
`ifdef REGS_FILE_WRITE_BYPASS_EN
      if (wrValid && (bus.A1 == bus.A3)) begin
         rd1 = bus.WD3;
      end
      if (wrValid && (bus.A2 == bus.A3)) begin
         rd2 = bus.WD3;
      end
`else
`endif
   end

   assign bus.RD1 = rd1;
   assign bus.RD2 = rd2;
endmodule

// File: tb/tb_regs_file.sv
// Directed self-checking bench for regs_file: reset, write/readback sweep, dual read,
// $zero protection, write-enable gating, reset priority and the optional write bypass.
module tb_regs_file;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   regs_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   regs_file #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [4:0] a3, input logic [31:0] wd3, input logic we3);
      rst     = r;
      bus.A1  = a1;
      bus.A2  = a2;
      bus.A3  = a3;
      bus.WD3 = wd3;
      bus.WE3 = we3;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Inputs change 1 time unit after the rising edge so outputs are sampled mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] expPre;
      logic [31:0] expBypass7;
      checks = 0;
      errors = 0;

      applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
      tick();
      tick();
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b0, i[4:0], 5'd31 - i[4:0], 5'd0, 32'h0, 1'b0);
         checkOutput($sformatf("reset_rd1_a%0d", i), bus.RD1, 32'h0);
         checkOutput($sformatf("reset_rd2_a%0d", 31 - i), bus.RD2, 32'h0);
      end

      for (int i = 1; i < 32; i++) begin
         applyStimulus(1'b0, 5'd0, 5'd0, i[4:0], i * 16, 1'b1);
         tick();
      end
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
      for (int i = 1; i < 32; i++) begin
         applyStimulus(1'b0, i[4:0], 5'd0, 5'd0, 32'h0, 1'b0);
         checkOutput($sformatf("readback_a%0d", i), bus.RD1, i * 16);
      end

      applyStimulus(1'b0, 5'd5, 5'd31, 5'd0, 32'h0, 1'b0);
      checkOutput("dual_rd1", bus.RD1, 32'h0000_0050);
      checkOutput("dual_rd2", bus.RD2, 32'h0000_01F0);

      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
      checkOutput("zero_same_cycle_rd1", bus.RD1, 32'h0);
      tick();
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
      checkOutput("zero_rd1", bus.RD1, 32'h0);
      checkOutput("zero_rd2", bus.RD2, 32'h0);
      applyStimulus(1'b0, 5'd1, 5'd16, 5'd0, 32'h0, 1'b0);
      checkOutput("zero_no_alias_r1", bus.RD1, 32'h0000_0010);
      checkOutput("zero_no_alias_r16", bus.RD2, 32'h0000_0100);

      applyStimulus(1'b0, 5'd7, 5'd7, 5'd7, 32'hDEAD_BEEF, 1'b0);
      tick();
      checkOutput("we_gate_rd1", bus.RD1, 32'h0000_0070);
      checkOutput("we_gate_rd2", bus.RD2, 32'h0000_0070);

`ifdef REGS_FILE_WRITE_BYPASS_EN
      expPre     = 32'hCAFE_F00D;
      expBypass7 = 32'h1234_5678;
`else
      expPre     = 32'h0000_0090;
      expBypass7 = 32'h0000_0070;
`endif
      applyStimulus(1'b0, 5'd9, 5'd9, 5'd9, 32'hCAFE_F00D, 1'b1);
      checkOutput("bypass_pre_rd1", bus.RD1, expPre);
      checkOutput("bypass_pre_rd2", bus.RD2, expPre);
      tick();
      applyStimulus(1'b0, 5'd9, 5'd8, 5'd0, 32'h0, 1'b0);
      checkOutput("bypass_post_rd1", bus.RD1, 32'hCAFE_F00D);
      checkOutput("bypass_post_neighbor", bus.RD2, 32'h0000_0080);

      applyStimulus(1'b1, 5'd7, 5'd0, 5'd7, 32'h1234_5678, 1'b1);
      checkOutput("rst_cycle_rd1", bus.RD1, expBypass7);
      tick();
      applyStimulus(1'b0, 5'd7, 5'd9, 5'd0, 32'h0, 1'b0);
      checkOutput("rst_priority_r7", bus.RD1, 32'h0);
      checkOutput("rst_clears_r9", bus.RD2, 32'h0);

      applyStimulus(1'b0, 5'd3, 5'd3, 5'd3, 32'hA5A5_5A5A, 1'b1);
      tick();
      applyStimulus(1'b0, 5'd3, 5'd31, 5'd0, 32'h0, 1'b0);
      checkOutput("post_rst_write_r3", bus.RD1, 32'hA5A5_5A5A);
      checkOutput("post_rst_r31", bus.RD2, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/regs_file.md
Name: regs_file

Overview:
- MIPS-style general-purpose register file: 32 registers × 32 bits.
- Two combinational read ports (RD1/RD2) and one synchronous write port (A3/WD3/WE3).
- Register 0 ($zero) is hardwired to zero.
- Sits in the decode stage; the datapath reads rs/rt through A1/A2 and writes results back through A3.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; register count is 2**ADDR_W (32).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous active-high reset.
- A1  input  ADDR_W  read address, port 1.
- A2  input  ADDR_W  read address, port 2.
- A3  input  ADDR_W  write address.
- WD3  input  DATA_W  write data.
- WE3  input  1  write enable, active high.
- RD1  output  DATA_W  read data for A1.
- RD2  output  DATA_W  read data for A2.

Behaviour:
- Storage: registers reg[1]..reg[31], each DATA_W bits. reg[0] has no storage; any read of address 0 returns 0.
- Reset: on a rising clk with rst=1, reg[1..31] all become 0.
  - Reset has priority over a simultaneous write; the write is dropped.
  - After reset, RD1 = RD2 = 0 for every address.
- Write: on a rising clk with rst=0, WE3=1 and A3≠0, reg[A3] <= WD3.
  - The new value is visible on the read ports after that edge (write latency 1 cycle).
  - WE3=0 means no state change.
  - A3=0 with WE3=1 is ignored; reg[0] stays 0.
- Read: RD1 = reg[A1] and RD2 = reg[A2], purely combinational with zero-cycle latency.
  - Both ports are independent and may address the same register.
  - There is no read enable.
- Same-cycle read/write of the same address (without the optional feature): the read ports show the old value until the clock edge, then the new value.
- Inputs are never X-propagated into storage when WE3=0. Writes happen only on the clock edge, never level-sensitive.
- There are no handshakes and no internal state machine.

Optional Feature:
- Macro: REGS_FILE_WRITE_BYPASS_EN.
- Defined: when WE3=1, A3≠0 and A1==A3, RD1 = WD3 combinationally, in the same cycle, before the edge. RD2 bypasses the same way when A2==A3.
  - Reset does not suppress the bypass; it only affects storage.
  - Address 0 never bypasses and always reads 0.
- Undefined: no bypass. Reads always return stored contents.

Test Plan:
- Reset: hold rst=1 for 2 cycles, release, then sweep A1 over 0..31 -> RD1 = 0x00000000 for every address.
- Write/readback: for i=1..31, write WD3=i*16 to A3=i with WE3=1 for one cycle each; then sweep A1=i -> RD1 = i*16 (e.g. A1=31 gives 0x000001F0).
- Dual-port read: set A1=5 and A2=31 together -> RD1 = 0x50 and RD2 = 0x1F0 in the same cycle.
- Zero register: write A3=0, WD3=0xFFFFFFFF, WE3=1, then read A1=0 and A2=0 -> both 0x00000000.
- Write-enable gating: write A3=7, WD3=0xDEADBEEF with WE3=0 -> A1=7 still reads 0x70.
  - Then assert rst and WE3=1 on the same edge with A3=7, WD3=0x12345678 -> A1=7 reads 0.
- Bypass:
  - With REGS_FILE_WRITE_BYPASS_EN defined: WE3=1, A3=A1=9, WD3=0xCAFEF00D -> RD1 = 0xCAFEF00D before the edge.
  - With the macro undefined, same stimulus -> RD1 shows the prior value before the edge and 0xCAFEF00D after it.
